simd_fir_mac: RTL and testbench
===============================

Name: simd_fir_mac

Overview:
- Parametrised SIMD multiply-accumulate engine that executes the FIR tap loop for the vector datapath.
- Takes LANES packed signed samples and coefficients per beat and keeps one wide accumulator per lane.
- On a drain op it emits Q-format-scaled, optionally saturated lane results plus a cross-lane reduction sum.
- Sits between the vector register file read port and the vector writeback/memory port (128-bit q_b/data_b path at default parameters).

Parameters:
- LANES, 8: number of parallel lanes.
- LANE_W, 16: signed sample/coefficient/result width per lane.
- ACC_W, 40: signed accumulator width per lane; must be >= 2*LANE_W.
- FRAC, 15: arithmetic right shift applied at drain (Q1.15 at default).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept a beat.
- op  in  2  00 MAC, 01 LOAD, 10 DRAIN, 11 DRAIN_CLR.
- sat_en  in  1  saturate drain results (sampled with the beat).
- a_vec  in  LANES*LANE_W  packed samples; lane i is bits [i*LANE_W +: LANE_W].
- b_vec  in  LANES*LANE_W  packed coefficients.
- out_valid  out  1  drain result valid.
- out_ready  in  1  consumer accepts result.
- out_vec  out  LANES*LANE_W  scaled lane results.
- out_sum  out  ACC_W+$clog2(LANES)  signed sum of all raw accumulators.
- ovf  out  LANES  per-lane flag: saturation/truncation clipped on this drain, or sticky accumulator wrap.

Behaviour:
- Reset (async, reset low): all stage valids 0, accumulators 0, sticky wrap flags 0, out_valid 0, out_vec 0, out_sum 0, ovf 0. in_ready reads 1 once reset is released.
- A beat is accepted when in_valid && in_ready.
- Pipeline has three stages: S1 registers signed products a*b (2*LANE_W wide) with op and sat_en; S2 updates/reads the accumulators; S3 holds the output register.
- Global stall: stall = out_valid && !out_ready. in_ready = !stall. While stalled, every stage and accumulator holds.
- MAC: acc[i] += sign-extended product.
- LOAD: acc[i] = product, and lane wrap flags clear.
- Either update happens in S2, one cycle after accept, and is visible to the next op in S2 (back-to-back MAC then DRAIN includes that MAC).
- Accumulator overflow: two's-complement wrap and sets sticky wrap[i]. wrap[i] clears only on LOAD or DRAIN_CLR.
- DRAIN: S2 reads acc after all earlier ops.
  - Lane result r = acc[i] >>> FRAC (arithmetic, truncating toward minus infinity).
  - If sat_en: clamp r to [-2^(LANE_W-1), 2^(LANE_W-1)-1]. Otherwise take the low LANE_W bits.
  - ovf[i] = (r out of range) | wrap[i].
  - out_sum = sum of all acc[i], sign-extended.
  - Registered into S3; out_valid rises 2 cycles after the accepting edge. Accumulators are unchanged.
- DRAIN_CLR: same output as DRAIN, then acc[i] and wrap[i] are cleared in the same S2 cycle.
- MAC/LOAD produce no output beat. out_valid stays asserted with stable data until out_ready.
- out_valid && out_ready with a new drain arriving from S2 in the same cycle: S3 reloads and out_valid stays 1 (full throughput, one result per cycle).
- Reset asserted mid-stream: all in-flight beats are discarded and accumulators clear immediately; no partial output.
- in_valid low: a bubble propagates and the accumulators are untouched.

Test Plan:
1. Basic MAC/drain, all lanes: LOAD 0x4000*0x4000, MAC 0x4000*0x4000, DRAIN sat_en=1 -> out_vec lanes all 0x4000, out_sum 0x100000000, ovf 0, out_valid exactly 2 cycles after DRAIN accept.
2. Saturation: LOAD then 2x MAC of 0x7FFF*0x7FFF (acc 0xBFFD0003), DRAIN sat_en=1 -> lane 0x7FFF, ovf=1. Repeat with sat_en=0 -> lane 0x7FFA, ovf=1.
3. Negative/truncation: LOAD 0x8000*0x4000 (acc -0x20000000), DRAIN -> lane 0xC000, ovf 0. Lane 3 product 0xFFFF*0x0001 -> lane result 0xFFFF (-1 floors).
4. Backpressure: out_ready=0 after a DRAIN, then present 3 MAC beats -> in_ready=0, out_vec stable, accumulators unchanged. Raise out_ready -> beats accepted in order; a following DRAIN reflects all 3.
5. DRAIN_CLR then DRAIN back-to-back -> first drain shows accumulated values, second shows all 0, out_sum 0, out_valid high 2 consecutive cycles.
6. Async reset: drop reset mid-MAC sequence between clock edges -> out_valid, ovf, and accumulators are 0 immediately. After release, DRAIN returns 0.

Source files
------------

// File: rtl/simd_fir_mac.sv
// SIMD multiply-accumulate engine for the FIR tap loop: per-lane wide accumulators,
// Q-format scaled drain with optional saturation, and a cross-lane reduction sum.
module simd_fir_mac #(
   parameter int LANES  = 8,
   parameter int LANE_W = 16,
   parameter int ACC_W  = 40,
   parameter int FRAC   = 15
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [1:0]                          op,
   input  logic                                sat_en,
   input  logic [LANES*LANE_W-1:0]             a_vec,
   input  logic [LANES*LANE_W-1:0]             b_vec,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [LANES*LANE_W-1:0]             out_vec,
   output logic [ACC_W+$clog2(LANES)-1:0]      out_sum,
   output logic [LANES-1:0]                    ovf
);

   localparam int PROD_W = 2 * LANE_W;
   localparam int SUM_W  = ACC_W + $clog2(LANES);
   localparam int HI_W   = ACC_W - LANE_W + 1;

   typedef enum logic [1:0] {
      OP_MAC       = 2'b00,
      OP_LOAD      = 2'b01,
      OP_DRAIN     = 2'b10,
      OP_DRAIN_CLR = 2'b11
   } op_e;

   logic stall;
   logic accept;

   logic                     s1_valid;
   op_e                      s1_op;
   logic                     s1_sat;
   logic signed [PROD_W-1:0] s1_prod [LANES];

   logic signed [ACC_W-1:0]  acc [LANES];
   logic [LANES-1:0]         wrap;

   logic                     s2_valid;
   logic [LANES*LANE_W-1:0]  s2_vec;
   logic [LANES-1:0]         s2_ovf;
   logic signed [SUM_W-1:0]  s2_sum;

   logic signed [ACC_W-1:0]  prod_ext [LANES];
   logic signed [ACC_W-1:0]  mac_sum [LANES];
   logic [LANES-1:0]         mac_wrap;
   logic signed [ACC_W-1:0]  shifted;
   logic [HI_W-1:0]          hi_bits;
   logic                     in_range;
   logic [LANES*LANE_W-1:0]  drain_vec;
   logic [LANES-1:0]         drain_ovf;
   logic signed [SUM_W-1:0]  drain_sum;
   logic                     s1_is_drain;

   // A held result that nobody takes freezes the whole pipe, accumulators included.
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;

   assign s1_is_drain = s1_valid && (s1_op == OP_DRAIN || s1_op == OP_DRAIN_CLR);

   // S1: product register; a bubble is recorded as s1_valid = 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_MAC;
         s1_sat   <= 1'b0;
         for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
      end else if (!stall) begin
         s1_valid <= accept;
         if (accept) begin
            s1_op  <= op_e'(op);
            s1_sat <= sat_en;
            for (int i = 0; i < LANES; i++)
               s1_prod[i] <= PROD_W'($signed(a_vec[i*LANE_W +: LANE_W]))
                           * PROD_W'($signed(b_vec[i*LANE_W +: LANE_W]));
         end
      end
   end

   // Accumulator update, wrap detection and drain formatting, all from the S1 beat.
   always_comb begin
      drain_vec = '0;
      drain_ovf = '0;
      drain_sum = '0;
      mac_wrap  = '0;
      shifted   = '0;
      hi_bits   = '0;
      in_range  = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         prod_ext[i] = ACC_W'(s1_prod[i]);
         mac_sum[i]  = acc[i] + prod_ext[i];
         mac_wrap[i] = (acc[i][ACC_W-1] == prod_ext[i][ACC_W-1])
                    && (mac_sum[i][ACC_W-1] != acc[i][ACC_W-1]);

         shifted  = acc[i] >>> FRAC;
         hi_bits  = shifted[ACC_W-1:LANE_W-1];
         in_range = (&hi_bits) | ~(|hi_bits);
         if (in_range || !s1_sat)
            drain_vec[i*LANE_W +: LANE_W] = shifted[LANE_W-1:0];
         else if (shifted[ACC_W-1])
            drain_vec[i*LANE_W +: LANE_W] = {1'b1, {(LANE_W-1){1'b0}}};
         else
            drain_vec[i*LANE_W +: LANE_W] = {1'b0, {(LANE_W-1){1'b1}}};
         drain_ovf[i] = !in_range || wrap[i];
         drain_sum    = drain_sum + SUM_W'(acc[i]);
      end
   end

   // S2 accumulators: a drain reads the value left by every earlier op, then DRAIN_CLR wipes it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LANES; i++) acc[i] <= '0;
         wrap <= '0;
      end else if (!stall && s1_valid) begin
         for (int i = 0; i < LANES; i++) begin
            case (s1_op)
               OP_MAC: begin
                  acc[i] <= mac_sum[i];
                  if (mac_wrap[i]) wrap[i] <= 1'b1;
               end
               OP_LOAD: begin
                  acc[i]  <= prod_ext[i];
                  wrap[i] <= 1'b0;
               end
               OP_DRAIN_CLR: begin
                  acc[i]  <= '0;
                  wrap[i] <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid <= 1'b0;
         s2_vec   <= '0;
         s2_ovf   <= '0;
         s2_sum   <= '0;
      end else if (!stall) begin
         s2_valid <= s1_is_drain;
         if (s1_is_drain) begin
            s2_vec <= drain_vec;
            s2_ovf <= drain_ovf;
            s2_sum <= drain_sum;
         end
      end
   end

   // S3 output register: holds until taken, reloads in the same cycle it is taken.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_vec   <= '0;
         out_sum   <= '0;
         ovf       <= '0;
      end else if (!stall) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            out_vec <= s2_vec;
            out_sum <= s2_sum;
            ovf     <= s2_ovf;
         end
      end
   end

endmodule

// File: tb/tb_simd_fir_mac.sv
// Directed bench for simd_fir_mac at default parameters; expected values are
// hand-computed Q1.15 results for uniform and mixed lane patterns.
module tb_simd_fir_mac;

   localparam int LANES  = 8;
   localparam int LANE_W = 16;
   localparam int ACC_W  = 40;
   localparam int SUM_W  = 43;
   localparam int VEC_W  = LANES * LANE_W;

   localparam logic [1:0] MAC       = 2'b00;
   localparam logic [1:0] LOAD      = 2'b01;
   localparam logic [1:0] DRAIN     = 2'b10;
   localparam logic [1:0] DRAIN_CLR = 2'b11;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        op;
   logic              sat_en;
   logic [VEC_W-1:0]  a_vec;
   logic [VEC_W-1:0]  b_vec;
   logic              out_valid;
   logic              out_ready;
   logic [VEC_W-1:0]  out_vec;
   logic [SUM_W-1:0]  out_sum;
   logic [LANES-1:0]  ovf;

   int checks = 0;
   int errors = 0;
   int lat;
   logic [VEC_W-1:0] exp_vec;
   logic [VEC_W-1:0] a_mix;
   logic [VEC_W-1:0] b_mix;

   always #5 clk = ~clk;

   simd_fir_mac #(.LANES(LANES), .LANE_W(LANE_W), .ACC_W(ACC_W), .FRAC(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .sat_en    (sat_en),
      .a_vec     (a_vec),
      .b_vec     (b_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec),
      .out_sum   (out_sum),
      .ovf       (ovf)
   );

   function automatic logic [VEC_W-1:0] rep(input logic [LANE_W-1:0] v);
      logic [VEC_W-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = v;
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [VEC_W-1:0] observed,
                              input logic [VEC_W-1:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Present one beat and return #1 after the edge that accepted it.
   task automatic applyStimulus(input logic [1:0] op_val, input logic sat_val,
                                input logic [VEC_W-1:0] a_val, input logic [VEC_W-1:0] b_val);
      int waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      op       = op_val;
      sat_en   = sat_val;
      a_vec    = a_val;
      b_vec    = b_val;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) checkOutput("accept_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic waitOut(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!out_valid && cyc < 20);
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      op        = MAC;
      sat_en    = 1'b0;
      a_vec     = '0;
      b_vec     = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_out_vec", out_vec, '0);
      checkOutput("rst_out_sum", out_sum, '0);
      checkOutput("rst_ovf", ovf, '0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("rst_in_ready", in_ready, 1'b1);

      // Basic MAC / drain
      applyStimulus(LOAD, 1'b1, rep(16'h4000), rep(16'h4000));
      applyStimulus(MAC, 1'b1, rep(16'h4000), rep(16'h4000));
      applyStimulus(DRAIN, 1'b1, '0, '0);
      waitOut(lat);
      checkOutput("t1_latency", lat, 2);
      checkOutput("t1_vec", out_vec, rep(16'h4000));
      checkOutput("t1_sum", out_sum, 43'h100000000);
      checkOutput("t1_ovf", ovf, '0);

      // Saturation and truncation of an out-of-range result
      applyStimulus(LOAD, 1'b1, rep(16'h7FFF), rep(16'h7FFF));
      applyStimulus(MAC, 1'b1, rep(16'h7FFF), rep(16'h7FFF));
      applyStimulus(MAC, 1'b1, rep(16'h7FFF), rep(16'h7FFF));
      applyStimulus(DRAIN, 1'b1, '0, '0);
      waitOut(lat);
      checkOutput("t2_sat_vec", out_vec, rep(16'h7FFF));
      checkOutput("t2_sat_ovf", ovf, 8'hFF);
      checkOutput("t2_sat_sum", out_sum, 43'h5FFE80018);
      applyStimulus(DRAIN, 1'b0, '0, '0);
      waitOut(lat);
      checkOutput("t2_trunc_vec", out_vec, rep(16'h7FFA));
      checkOutput("t2_trunc_ovf", ovf, 8'hFF);

      // Negative values and flooring of -1
      a_mix = rep(16'h8000);
      b_mix = rep(16'h4000);
      a_mix[3*LANE_W +: LANE_W] = 16'hFFFF;
      b_mix[3*LANE_W +: LANE_W] = 16'h0001;
      exp_vec = rep(16'hC000);
      exp_vec[3*LANE_W +: LANE_W] = 16'hFFFF;
      applyStimulus(LOAD, 1'b1, a_mix, b_mix);
      applyStimulus(DRAIN, 1'b1, '0, '0);
      waitOut(lat);
      checkOutput("t3_vec", out_vec, exp_vec);
      checkOutput("t3_sum", out_sum, 43'h7FF1FFFFFFF);
      checkOutput("t3_ovf", ovf, '0);

      // Accumulator wrap: sticky until cleared, even after the value returns in range
      applyStimulus(LOAD, 1'b1, rep(16'h8000), rep(16'h8000));
      for (int k = 0; k < 511; k++) applyStimulus(MAC, 1'b1, rep(16'h8000), rep(16'h8000));
      applyStimulus(DRAIN, 1'b1, '0, '0);
      waitOut(lat);
      checkOutput("wrap_vec", out_vec, rep(16'h8000));
      checkOutput("wrap_ovf", ovf, 8'hFF);
      checkOutput("wrap_sum", out_sum, 43'h40000000000);
      for (int k = 0; k < 512; k++) applyStimulus(MAC, 1'b1, rep(16'h8000), rep(16'h8000));
      applyStimulus(DRAIN, 1'b1, '0, '0);
      waitOut(lat);
      checkOutput("wrap_sticky_vec", out_vec, '0);
      checkOutput("wrap_sticky_ovf", ovf, 8'hFF);
      applyStimulus(DRAIN_CLR, 1'b0, '0, '0);
      waitOut(lat);
      checkOutput("wrap_clr_ovf", ovf, 8'hFF);
      applyStimulus(DRAIN, 1'b0, '0, '0);
      waitOut(lat);
      checkOutput("wrap_after_clr_ovf", ovf, '0);

      // Backpressure: stalled result holds, new beats wait
      applyStimulus(LOAD, 1'b1, rep(16'h4000), rep(16'h4000));
      out_ready = 1'b0;
      applyStimulus(DRAIN, 1'b1, '0, '0);
      waitOut(lat);
      checkOutput("t4_first_vec", out_vec, rep(16'h2000));
      @(negedge clk);
      in_valid = 1'b1;
      op       = MAC;
      a_vec    = rep(16'h4000);
      b_vec    = rep(16'h4000);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("t4_stall_in_ready", in_ready, 1'b0);
         checkOutput("t4_stall_valid", out_valid, 1'b1);
         checkOutput("t4_stall_vec", out_vec, rep(16'h2000));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      applyStimulus(MAC, 1'b1, rep(16'h2000), rep(16'h4000));
      applyStimulus(MAC, 1'b1, rep(16'h0100), rep(16'h4000));
      applyStimulus(DRAIN, 1'b1, '0, '0);
      waitOut(lat);
      checkOutput("t4_final_vec", out_vec, rep(16'h5080));
      checkOutput("t4_final_sum", out_sum, 43'h142000000);

      // DRAIN_CLR then DRAIN back to back
      applyStimulus(DRAIN_CLR, 1'b1, '0, '0);
      applyStimulus(DRAIN, 1'b1, '0, '0);
      checkOutput("t5_not_yet", out_valid, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("t5_first_valid", out_valid, 1'b1);
      checkOutput("t5_first_vec", out_vec, rep(16'h5080));
      checkOutput("t5_first_sum", out_sum, 43'h142000000);
      @(posedge clk);
      #1;
      checkOutput("t5_second_valid", out_valid, 1'b1);
      checkOutput("t5_second_vec", out_vec, '0);
      checkOutput("t5_second_sum", out_sum, '0);
      @(posedge clk);
      #1;
      checkOutput("t5_idle_valid", out_valid, 1'b0);

      // Asynchronous reset between clock edges
      applyStimulus(LOAD, 1'b1, rep(16'h7FFF), rep(16'h7FFF));
      applyStimulus(MAC, 1'b1, rep(16'h7FFF), rep(16'h7FFF));
      applyStimulus(MAC, 1'b1, rep(16'h7FFF), rep(16'h7FFF));
      out_ready = 1'b0;
      applyStimulus(DRAIN, 1'b1, '0, '0);
      waitOut(lat);
      checkOutput("t6_pre_ovf", ovf, 8'hFF);
      in_valid = 1'b1;
      op       = MAC;
      a_vec    = rep(16'h4000);
      b_vec    = rep(16'h4000);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      checkOutput("t6_rst_valid", out_valid, 1'b0);
      checkOutput("t6_rst_ovf", ovf, '0);
      checkOutput("t6_rst_vec", out_vec, '0);
      in_valid = 1'b0;
      @(negedge clk);
      reset     = 1'b1;
      out_ready = 1'b1;
      applyStimulus(DRAIN, 1'b1, '0, '0);
      waitOut(lat);
      checkOutput("t6_post_valid", out_valid, 1'b1);
      checkOutput("t6_post_vec", out_vec, '0);
      checkOutput("t6_post_sum", out_sum, '0);
      checkOutput("t6_post_ovf", ovf, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
